cache_ctrl: RTL and testbench

Request sequencer for the 2-way, 8-set, 32-byte-line cache datapath. It accepts one byte-wide CPU access at a time and presents the address to the cache for lookup. On a miss it fetches the 256-bit line from memory, strobes it into the FIFO-selected victim way, and replays the lookup. Writes go to the cache and through to memory, and the block keeps saturating hit and miss statistics.

---
 rtl/cache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl
// Request sequencer for a 2-way, 8-set, 32-byte-line cache datapath.
// It takes one byte-wide CPU access at a time and sends the latched
// address to the datapath for lookup. On a miss it fetches the line from
// memory, fills the victim way and replays the lookup. Writes update the
// cache and go through to memory. Saturating hit and miss counters are kept.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   cpu_req/addr/we/wdata   CPU request, sampled only when idle
//   cpu_ready, cpu_rdata    completion pulse and read byte
//   busy                    high whenever not idle
//   cache_addr              latched address driven to the datapath
//   cache_hit, cache_rdata  datapath lookup result
//   cache_mem_write, cache_wbyte   byte write into the hit line
//   cache_fill, cache_block        refill strobe and line data
//   mem_rd_req/addr/valid/data     line read from memory
//   mem_wr_req/addr/data/ack       write-through to memory
//   hit_cnt, miss_cnt              saturating statistics
module cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic               cpu_we,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ready,
  output logic [7:0]         cpu_rdata,
  output logic               busy,
  output logic [ADDR_W-1:0]  cache_addr,
  input  logic               cache_hit,
  input  logic [7:0]         cache_rdata,
  output logic               cache_mem_write,
  output logic [7:0]         cache_wbyte,
  output logic               cache_fill,
  output logic [BLOCK_W-1:0] cache_block,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic               mem_rd_valid,
  input  logic [BLOCK_W-1:0] mem_rd_data,
  output logic               mem_wr_req,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [7:0]         mem_wr_data,
  input  logic               mem_wr_ack,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    FILL,
    WRITE,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic       we_q;
  logic [7:0] wdata_q;
  logic       replay;
  logic       wr_first;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. A replayed lookup that misses again simply goes
  // back to REFILL; the replay flag keeps it out of the statistics.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu_req) state_next = LOOKUP;
      LOOKUP: begin
        if (!cache_hit)  state_next = REFILL;
        else if (we_q)   state_next = WRITE;
        else             state_next = RESP;
      end
      REFILL:  if (mem_rd_valid) state_next = FILL;
      FILL:    state_next = LOOKUP;
      WRITE:   if (mem_wr_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches, read data, refill line, replay flag and statistics.
  // wr_first marks the first WRITE cycle so the cache byte write happens
  // once even when the memory acknowledge takes several cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_addr  <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      replay      <= 1'b0;
      wr_first    <= 1'b0;
      cpu_rdata   <= '0;
      cache_block <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            cache_addr <= cpu_addr;
            we_q       <= cpu_we;
            wdata_q    <= cpu_wdata;
            replay     <= 1'b0;
          end
        end
        LOOKUP: begin
          if (cache_hit) begin
            if (we_q) begin
              wr_first <= 1'b1;
            end else begin
              cpu_rdata <= cache_rdata;
            end
          end
          if (!replay) begin
            if (cache_hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
          end
        end
        REFILL: begin
          if (mem_rd_valid) cache_block <= mem_rd_data;
        end
        FILL: begin
          replay <= 1'b1;
        end
        WRITE: begin
          wr_first <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state and registered values only, so a reset
  // drops any outstanding memory request immediately.
  assign busy            = (state != IDLE);
  assign cpu_ready       = (state == RESP);
  assign cache_fill      = (state == FILL);
  assign mem_rd_req      = (state == REFILL);
  assign mem_wr_req      = (state == WRITE);
  assign cache_mem_write = (state == WRITE) && wr_first;
  assign cache_wbyte     = wdata_q;
  assign mem_rd_addr     = {cache_addr[ADDR_W-1:5], 5'b0};
  assign mem_wr_addr     = cache_addr;
  assign mem_wr_data     = wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl
// Self-checking bench for cache_ctrl. It models the cache datapath
// (2-way, 8-set, FIFO victim, byte 0 of a line in the top bits) and a
// line-addressed backing memory, and predicts every access from a
// per-set FIFO of resident tags, the memory contents and the latency table.
// Counters are narrowed to 5 bits so saturation is reachable quickly.
module tb_cache_ctrl;

  localparam int ADDR_W  = 32;
  localparam int BLOCK_W = 256;
  localparam int CNT_W   = 5;
  localparam int MAX_CNT = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               cpu_req;
  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_we;
  logic [7:0]         cpu_wdata;
  logic               cpu_ready;
  logic [7:0]         cpu_rdata;
  logic               busy;
  logic [ADDR_W-1:0]  cache_addr;
  logic               cache_hit;
  logic [7:0]         cache_rdata;
  logic               cache_mem_write;
  logic [7:0]         cache_wbyte;
  logic               cache_fill;
  logic [BLOCK_W-1:0] cache_block;
  logic               mem_rd_req;
  logic [ADDR_W-1:0]  mem_rd_addr;
  logic               mem_rd_valid;
  logic [BLOCK_W-1:0] mem_rd_data;
  logic               mem_wr_req;
  logic [ADDR_W-1:0]  mem_wr_addr;
  logic [7:0]         mem_wr_data;
  logic               mem_wr_ack;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .busy(busy),
    .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .cache_mem_write(cache_mem_write), .cache_wbyte(cache_wbyte),
    .cache_fill(cache_fill), .cache_block(cache_block),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Cache datapath model: lookup is combinational from cache_addr,
  // fills go to the FIFO victim way, byte writes go to the hit way.
  logic               dpValid [8][2];
  logic [23:0]        dpTag   [8][2];
  logic [BLOCK_W-1:0] dpData  [8][2];
  logic               dpPtr   [8];
  logic [2:0]         dpIdx;
  logic [4:0]         dpOff;
  logic               dpHitWay;
  logic [BLOCK_W-1:0] dpLine;

  initial begin
    for (int s = 0; s < 8; s++) begin
      dpPtr[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        dpValid[s][w] = 1'b0;
        dpTag[s][w]   = '0;
        dpData[s][w]  = '0;
      end
    end
  end

  always_comb begin
    dpIdx    = cache_addr[7:5];
    dpOff    = cache_addr[4:0];
    cache_hit = 1'b0;
    dpHitWay = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (dpValid[dpIdx][w] && dpTag[dpIdx][w] == cache_addr[31:8]) begin
        cache_hit = 1'b1;
        dpHitWay  = w[0];
      end
    end
    dpLine      = dpData[dpIdx][dpHitWay];
    cache_rdata = dpLine[8*(31-dpOff) +: 8];
  end

  always @(posedge clk) begin
    if (cache_fill) begin
      dpData[dpIdx][dpPtr[dpIdx]]  <= cache_block;
      dpTag[dpIdx][dpPtr[dpIdx]]   <= cache_addr[31:8];
      dpValid[dpIdx][dpPtr[dpIdx]] <= 1'b1;
      dpPtr[dpIdx]                 <= ~dpPtr[dpIdx];
    end
    if (cache_mem_write && cache_hit) begin
      dpData[dpIdx][dpHitWay][8*(31-dpOff) +: 8] <= cache_wbyte;
    end
  end

  // Backing memory, one 256-bit entry per line, created on first touch.
  logic [BLOCK_W-1:0] memLines [int unsigned];

  function automatic logic [BLOCK_W-1:0] getLine(input logic [31:0] la);
    logic [BLOCK_W-1:0] v;
    if (!memLines.exists(la)) begin
      for (int i = 0; i < 8; i++) v[32*i +: 32] = (la * 32'(i + 3)) ^ 32'hA5C3_5A3C;
      memLines[la] = v;
    end
    return memLines[la];
  endfunction

  function automatic logic [7:0] getByte(input logic [31:0] a);
    logic [BLOCK_W-1:0] l;
    l = getLine({a[31:5], 5'b0});
    return l[8*(31-int'(a[4:0])) +: 8];
  endfunction

  task automatic setByte(input logic [31:0] a, input logic [7:0] b);
    logic [BLOCK_W-1:0] l;
    l = getLine({a[31:5], 5'b0});
    l[8*(31-int'(a[4:0])) +: 8] = b;
    memLines[{a[31:5], 5'b0}] = l;
  endtask

  // Reference: resident tags per set in fill order, counters, last read byte.
  logic [23:0] refSet [8][$];
  int          refHits;
  int          refMisses;
  logic [7:0]  refRdata;

  int tests;
  int failures;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Per-transaction observations
  int          readyCycle;
  int          fillCount;
  int          fillCycle;
  int          memWriteCount;
  logic [7:0]  wbyteSeen;
  int          rdReqCycles;
  int          wrReqCycles;
  logic [31:0] rdAddrSeen;
  logic [31:0] wrAddrSeen;
  logic [7:0]  wrDataSeen;
  logic [7:0]  rdataSeen;

  // One complete CPU access; memory answers after n read-request cycles
  // and a write-request cycles. Called and returns on a falling edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic we,
                               input logic [7:0] wdata, input int n,
                               input int a, input bit pokeBusy);
    logic [2:0]  idx;
    logic [23:0] tag;
    bit          hitExp;
    bit          done;
    logic [7:0]  expByte;
    int          k;
    int          expReady;
    idx     = addr[7:5];
    tag     = addr[31:8];
    hitExp  = 1'b0;
    for (int j = 0; j < refSet[idx].size(); j++) if (refSet[idx][j] == tag) hitExp = 1'b1;
    expByte = getByte(addr);

    readyCycle = -1; fillCount = 0; fillCycle = -1; memWriteCount = 0;
    wbyteSeen = '0; rdReqCycles = 0; wrReqCycles = 0;
    rdAddrSeen = '0; wrAddrSeen = '0; wrDataSeen = '0; rdataSeen = '0;

    cpu_req = 1'b1; cpu_addr = addr; cpu_we = we; cpu_wdata = wdata;
    k = 0; done = 1'b0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        cpu_addr  = $urandom;
        cpu_we    = 1'($urandom);
        cpu_wdata = 8'($urandom);
      end
      cpu_req = pokeBusy && (k == 2);
      if (cache_fill) begin fillCount++; fillCycle = k; end
      if (cache_mem_write) begin memWriteCount++; wbyteSeen = cache_wbyte; end
      if (mem_rd_req) begin
        rdAddrSeen   = mem_rd_addr;
        mem_rd_valid = (rdReqCycles == n);
        mem_rd_data  = (rdReqCycles == n) ? getLine(mem_rd_addr) : {8{$urandom}};
        rdReqCycles++;
      end else begin
        mem_rd_valid = 1'b0;
      end
      if (mem_wr_req) begin
        wrAddrSeen = mem_wr_addr;
        wrDataSeen = mem_wr_data;
        mem_wr_ack = (wrReqCycles == a);
        if (wrReqCycles == a) setByte(mem_wr_addr, mem_wr_data);
        wrReqCycles++;
      end else begin
        mem_wr_ack = 1'b0;
      end
      if (cpu_ready) begin
        readyCycle = k;
        rdataSeen  = cpu_rdata;
        done       = 1'b1;
      end
    end
    cpu_req = 1'b0; mem_rd_valid = 1'b0; mem_wr_ack = 1'b0;
    checkOutput("ready_seen", done, 1'b1);

    if (hitExp) expReady = we ? 3 + a : 2;
    else        expReady = we ? 6 + n + a : 5 + n;
    if (!we) refRdata = expByte;
    if (hitExp) begin if (refHits < MAX_CNT) refHits++; end
    else begin if (refMisses < MAX_CNT) refMisses++; end
    if (!hitExp) begin
      refSet[idx].push_back(tag);
      if (refSet[idx].size() > 2) void'(refSet[idx].pop_front());
    end

    checkOutput("ready_cycle", 32'(readyCycle), 32'(expReady));
    checkOutput("fill_count", 32'(fillCount), hitExp ? 0 : 1);
    checkOutput("cache_write_count", 32'(memWriteCount), we ? 1 : 0);
    checkOutput("rd_req_cycles", 32'(rdReqCycles), hitExp ? 0 : 32'(n + 1));
    checkOutput("wr_req_cycles", 32'(wrReqCycles), we ? 32'(a + 1) : 0);
    checkOutput("cpu_rdata", rdataSeen, refRdata);
    checkOutput("hit_cnt", hit_cnt, 32'(refHits));
    checkOutput("miss_cnt", miss_cnt, 32'(refMisses));
    if (!hitExp) begin
      checkOutput("mem_rd_addr", rdAddrSeen, {addr[31:5], 5'b0});
      checkOutput("fill_cycle", 32'(fillCycle), 32'(3 + n));
    end
    if (we) begin
      checkOutput("cache_wbyte", wbyteSeen, wdata);
      checkOutput("mem_wr_addr", wrAddrSeen, addr);
      checkOutput("mem_wr_data", wrDataSeen, wdata);
    end

    @(negedge clk);
    checkOutput("ready_single", cpu_ready, 1'b0);
    checkOutput("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int k;
    logic [31:0] ra;
    tests = 0; failures = 0;
    refHits = 0; refMisses = 0; refRdata = '0;
    reset = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
    mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", cpu_ready, 1'b0);
    checkOutput("rst_rdata", cpu_rdata, 8'h00);
    checkOutput("rst_cache_addr", cache_addr, 32'h0);
    checkOutput("rst_block", cache_block, 256'h0);
    checkOutput("rst_rd_req", mem_rd_req, 1'b0);
    checkOutput("rst_wr_req", mem_wr_req, 1'b0);
    checkOutput("rst_fill", cache_fill, 1'b0);
    checkOutput("rst_counts", {hit_cnt, miss_cnt}, 10'h0);
    reset = 1'b1;
    @(negedge clk);

    // Read miss then hit
    memLines[32'h00a00060] = 256'h123456;
    applyStimulus(32'h00a00062, 1'b0, 8'h00, 2, 0, 1'b0);
    checkOutput("tp_miss_ready", 32'(readyCycle), 32'd7);
    checkOutput("tp_miss_rdata", rdataSeen, 8'h00);
    checkOutput("tp_fill_cycle", 32'(fillCycle), 32'd5);
    applyStimulus(32'h00a00062, 1'b0, 8'h00, 0, 0, 1'b0);
    checkOutput("tp_hit_ready", 32'(readyCycle), 32'd2);

    // Write hit, write miss
    applyStimulus(32'h00a00062, 1'b1, 8'h09, 0, 1, 1'b0);
    checkOutput("tp_wr_ready", 32'(readyCycle), 32'd4);
    applyStimulus(32'h12345678, 1'b1, 8'h5e, 1, 2, 1'b0);
    applyStimulus(32'h12345678, 1'b0, 8'h00, 0, 0, 1'b0);
    checkOutput("tp_wr_readback", rdataSeen, 8'h5e);

    // Reset during REFILL
    cpu_req = 1'b1; cpu_addr = 32'h00b000c4; cpu_we = 1'b0;
    @(negedge clk);
    cpu_req = 1'b0;
    k = 1;
    while (!mem_rd_req && k < 20) begin @(negedge clk); k++; end
    checkOutput("mid_rd_req_seen", mem_rd_req, 1'b1);
    #1 reset = 1'b0;
    #1;
    checkOutput("mid_rd_req_drop", mem_rd_req, 1'b0);
    checkOutput("mid_busy", busy, 1'b0);
    checkOutput("mid_ready", cpu_ready, 1'b0);
    checkOutput("mid_cache_addr", cache_addr, 32'h0);
    checkOutput("mid_counts", {hit_cnt, miss_cnt, cpu_rdata}, 18'h0);
    refHits = 0; refMisses = 0; refRdata = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(32'h00b000c4, 1'b0, 8'h00, 1, 0, 1'b0);

    // Request pulsed while busy is ignored
    applyStimulus(32'h00c00020, 1'b0, 8'h00, 3, 0, 1'b1);

    // Randomized accesses over a small address pool to mix hits and evictions
    for (int t = 0; t < 60; t++) begin
      ra = {24'h00a000 + 24'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            5'($urandom_range(0, 31))};
      applyStimulus(ra, 1'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Miss counter saturation
    for (int t = 0; t < MAX_CNT + 6; t++) begin
      applyStimulus({24'h300000 + 24'(t), 3'd5, 5'd1}, 1'b0, 8'h00, 0, 0, 1'b0);
    end
    checkOutput("sat_miss", miss_cnt, 32'(MAX_CNT));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
